// File: rtl/coef_pkg.sv
// Shared types and default constants for the coefficient loader slice.
package coef_pkg;

  localparam int COEF_DW    = 16;
  localparam int COEF_DEPTH = 64;

  // Number of bytes per word for a given word width (width is a multiple of 8).
  function automatic int coef_nb(input int dw);
    return dw / 8;
  endfunction

  localparam int COEF_NB = coef_nb(COEF_DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COEF = 2'd1,
    CSUM = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/coef_loader_if.sv
// Byte stream in, coefficient memory write port out.
interface coef_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64
) ();
  localparam int AW = $clog2(DEPTH);

  logic                  s_valid;
  logic [7:0]            s_data;
  logic                  s_ready;
  logic                  cload;
  logic [AW-1:0]         caddr;
  logic [DATA_WIDTH-1:0] cin;

  // Host side: drives the stream, observes the memory writes.
  modport master (
    output s_valid, s_data,
    input  s_ready, cload, caddr, cin
  );

  // Loader side.
  modport slave (
    input  s_valid, s_data,
    output s_ready, cload, caddr, cin
  );
endinterface

// File: rtl/coef_loader_byte_packer.sv
// Little-endian byte-to-word packer. word/word_valid are combinational on the
// cycle the last byte is accepted so the caller can register them directly.
module byte_packer
  import coef_pkg::*;
#(
  parameter int DATA_WIDTH = COEF_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_fire,
  input  logic [7:0]            in_byte,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word
);
  localparam int NB = coef_nb(DATA_WIDTH);
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] merged_s;
  logic                  last_s;

  // Merge the incoming byte into its lane and flag word completion.
  always_comb begin
    merged_s = data_q;
    merged_s[{cnt_q, 3'b000} +: 8] = in_byte;
    last_s     = (cnt_q == CW'(NB - 1));
    word_valid = in_fire && last_s;
    word       = merged_s;
  end

  // Next byte count and partial word; a completed word leaves the lanes empty.
  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    if (clr) begin
      cnt_d  = {CW{1'b0}};
      data_d = {DATA_WIDTH{1'b0}};
    end else if (in_fire) begin
      if (last_s) begin
        cnt_d  = {CW{1'b0}};
        data_d = {DATA_WIDTH{1'b0}};
      end else begin
        cnt_d  = cnt_q + CW'(1);
        data_d = merged_s;
      end
    end else begin
      cnt_d  = cnt_q;
      data_d = data_q;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= {CW{1'b0}};
      data_q <= {DATA_WIDTH{1'b0}};
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/coef_loader.sv
// Coefficient memory loader: packs a byte stream into DEPTH words, writes each
// one to the coefficient memory, then verifies a trailing modular checksum.
module coef_loader
  import coef_pkg::*;
#(
  parameter int DATA_WIDTH = COEF_DW,
  parameter int DEPTH      = COEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  coef_loader_if.slave bus,
  output logic         busy,
  output logic         load_done,
  output logic         load_err
);
  localparam int AW = $clog2(DEPTH);

  state_e                state_q, state_d;
  logic [AW-1:0]         widx_q, widx_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  cload_q, cload_d;
  logic [AW-1:0]         caddr_q, caddr_d;
  logic [DATA_WIDTH-1:0] cin_q, cin_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;

  logic                  start_acc_s;
  logic                  fire_s;
  logic                  word_valid_s;
  logic [DATA_WIDTH-1:0] word_s;
  logic                  last_word_s;

  // A start is honoured only when no session is running.
  always_comb begin
    start_acc_s = start && ((state_q == IDLE) || (state_q == DONE));
    fire_s      = bus.s_valid && ready_q;
    last_word_s = (widx_q == AW'(DEPTH - 1));
  end

  byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_acc_s),
    .in_fire    (fire_s),
    .in_byte    (bus.s_data),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = COEF;
        else       state_d = IDLE;
      end
      COEF: begin
        if (word_valid_s && last_word_s) state_d = CSUM;
        else                             state_d = COEF;
      end
      CSUM: begin
        if (word_valid_s) state_d = DONE;
        else              state_d = CSUM;
      end
      DONE: begin
        if (start) state_d = COEF;
        else       state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and datapath next values (word index, checksum, write port).
  always_comb begin
    widx_d  = widx_q;
    sum_d   = sum_q;
    cload_d = 1'b0;
    caddr_d = caddr_q;
    cin_d   = cin_q;
    err_d   = err_q;
    done_d  = (state_q == CSUM) && (state_d == DONE);
    ready_d = (state_d == COEF) || (state_d == CSUM);
    if (start_acc_s) begin
      widx_d = {AW{1'b0}};
      sum_d  = {DATA_WIDTH{1'b0}};
      err_d  = 1'b0;
    end else if (word_valid_s && (state_q == COEF)) begin
      cload_d = 1'b1;
      caddr_d = widx_q;
      cin_d   = word_s;
      sum_d   = sum_q + word_s;
      if (last_word_s) widx_d = widx_q;
      else             widx_d = widx_q + AW'(1);
    end else if (word_valid_s && (state_q == CSUM)) begin
      err_d = (word_s != sum_q);
    end else begin
      widx_d = widx_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      widx_q  <= {AW{1'b0}};
      sum_q   <= {DATA_WIDTH{1'b0}};
      cload_q <= 1'b0;
      caddr_q <= {AW{1'b0}};
      cin_q   <= {DATA_WIDTH{1'b0}};
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      widx_q  <= widx_d;
      sum_q   <= sum_d;
      cload_q <= cload_d;
      caddr_q <= caddr_d;
      cin_q   <= cin_d;
      err_q   <= err_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // Drive the ports from registers; busy covers exactly the stream-accepting states.
  always_comb begin
    bus.s_ready = ready_q;
    bus.cload   = cload_q;
    bus.caddr   = caddr_q;
    bus.cin     = cin_q;
    busy        = ready_q;
    load_done   = done_q;
    load_err    = err_q;
  end
endmodule
